// File: rtl/chain_tee.sv
// Bus-and-tag tee: splices N_DEV local devices and a downstream segment A onto
// upstream channel B, with a select-out priority chain, ownership tracking and contention count.
module chain_tee #(
  parameter int unsigned       N_DEV       = 4,
  parameter logic              PRIORITY    = 1'b1,
  parameter logic [N_DEV-1:0]  BYPASS_MASK = '0,
  parameter int unsigned       CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [8:0]           b_bus_out,
  input  logic [6:0]           b_tag_out,
  output logic [8:0]           b_bus_in,
  output logic [5:0]           b_tag_in,
  output logic [8:0]           a_bus_out,
  output logic [6:0]           a_tag_out,
  input  logic [8:0]           a_bus_in,
  input  logic [5:0]           a_tag_in,
  output logic [9*N_DEV-1:0]   dev_bus_out,
  output logic [6*N_DEV-1:0]   dev_tag_out,
  input  logic [9*N_DEV-1:0]   dev_bus_in,
  input  logic [5*N_DEV-1:0]   dev_tag_in,
  output logic [N_DEV-1:0]     dev_selection_x,
  input  logic [N_DEV-1:0]     dev_selection_y,
  output logic                 connected,
  output logic [3:0]           owner,
  output logic [CNT_W-1:0]     contention_count
);

  localparam int unsigned BUS_W = 9;
  localparam int unsigned DTO_W = 6;
  localparam int unsigned DTI_W = 5;
  localparam int unsigned N_SRC = N_DEV + 1;
  localparam int unsigned OWN_W = 4;
  localparam int unsigned POP_W = 4;

  typedef enum logic {IDLE, CONNECTED} state_t;

  state_t                 state;
  logic [BUS_W-1:0]       src_bus [N_SRC];
  logic [DTI_W-1:0]       src_tag [N_SRC];  // {service,status,address,request,operational}
  logic [N_SRC-1:0]       op_vec;
  logic [BUS_W-1:0]       or_bus;
  logic [DTI_W-1:0]       or_tag;
  logic [POP_W-1:0]       pop;
  logic [OWN_W-1:0]       single_idx;
  logic                   owner_op_c;
  logic                   take_c;
  logic                   drop_c;
  logic                   conn_c;
  logic [OWN_W-1:0]       own_c;
  logic [BUS_W-1:0]       g_bus_c;
  logic [DTI_W-1:0]       g_tag_c;
  logic [N_DEV-1:0]       sel_x_c;
  logic                   sel_run;
  logic                   a_sel_c;
  logic                   b_sel_c;
  logic [9*N_DEV-1:0]     dev_bus_c;
  logic [6*N_DEV-1:0]     dev_tag_c;

  // Normalise every source; bypassed devices contribute nothing.
  always_comb begin
    op_vec     = '0;
    or_bus     = '0;
    or_tag     = '0;
    pop        = '0;
    single_idx = '0;
    for (int i = 0; i < int'(N_DEV); i++) begin
      src_bus[i] = BYPASS_MASK[i] ? '0 : dev_bus_in[i*BUS_W +: BUS_W];
      src_tag[i] = BYPASS_MASK[i] ? '0 : dev_tag_in[i*DTI_W +: DTI_W];
    end
    src_bus[N_DEV] = a_bus_in;
    src_tag[N_DEV] = {a_tag_in[5:3], a_tag_in[1:0]};
    for (int i = 0; i < int'(N_SRC); i++) begin
      op_vec[i] = src_tag[i][0];
      or_bus    = or_bus | src_bus[i];
      or_tag    = or_tag | src_tag[i];
      if (src_tag[i][0]) begin
        pop        = pop + POP_W'(1);
        single_idx = OWN_W'(i);
      end
    end
  end

  // Connection decisions; gating follows the state being entered this edge.
  always_comb begin
    owner_op_c = |(op_vec & (N_SRC'(1) << owner));
    take_c     = (state == IDLE) && (pop == POP_W'(1)) && b_tag_out[0];
    drop_c     = (state == CONNECTED) && (!owner_op_c || !b_tag_out[0]);
    conn_c     = take_c || ((state == CONNECTED) && !drop_c);
    own_c      = take_c ? single_idx : owner;
    g_bus_c    = or_bus;
    g_tag_c    = or_tag;
    if (conn_c) begin
      for (int i = 0; i < int'(N_SRC); i++) begin
        if (own_c == OWN_W'(i)) begin
          g_bus_c = src_bus[i];
          g_tag_c = {src_tag[i][4:2], or_tag[1], src_tag[i][0]};
        end
      end
    end
  end

  // Select chain through unmasked devices, placed before or after A.
  always_comb begin
    sel_x_c = '0;
    sel_run = PRIORITY ? b_tag_out[2] : a_tag_in[2];
    for (int i = 0; i < int'(N_DEV); i++) begin
      if (!BYPASS_MASK[i]) begin
        sel_x_c[i] = sel_run;
        sel_run    = dev_selection_y[i];
      end
    end
    a_sel_c = PRIORITY ? sel_run : b_tag_out[2];
    b_sel_c = PRIORITY ? a_tag_in[2] : sel_run;
  end

  always_comb begin
    dev_bus_c = '0;
    dev_tag_c = '0;
    for (int i = 0; i < int'(N_DEV); i++) begin
      if (!BYPASS_MASK[i]) begin
        dev_bus_c[i*BUS_W +: BUS_W] = b_bus_out;
        dev_tag_c[i*DTO_W +: DTO_W] = {b_tag_out[6:3], b_tag_out[1:0]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state            <= IDLE;
      owner            <= '0;
      connected        <= 1'b0;
      contention_count <= '0;
      b_bus_in         <= '0;
      b_tag_in         <= '0;
      a_bus_out        <= '0;
      a_tag_out        <= '0;
      dev_bus_out      <= '0;
      dev_tag_out      <= '0;
      dev_selection_x  <= '0;
    end else begin
      case (state)
        IDLE:      if (take_c) begin
                     state <= CONNECTED;
                     owner <= single_idx;
                   end
        CONNECTED: if (drop_c) state <= IDLE;
        default:   state <= IDLE;
      endcase
      connected <= conn_c;
      if (pop > POP_W'(1) && contention_count != {CNT_W{1'b1}})
        contention_count <= contention_count + CNT_W'(1);
      b_bus_in        <= g_bus_c;
      b_tag_in        <= {g_tag_c[4:2], b_sel_c, g_tag_c[1:0]};
      a_bus_out       <= b_bus_out;
      a_tag_out       <= {b_tag_out[6:3], a_sel_c, b_tag_out[1:0]};
      dev_bus_out     <= dev_bus_c;
      dev_tag_out     <= dev_tag_c;
      dev_selection_x <= sel_x_c;
    end
  end

endmodule

// File: tb/tb_chain_tee.sv
// Bench for chain_tee: two configurations driven in parallel, scoreboarded against
// a behavioural model, plus hand-computed vector rows and corner sequences.
module tb_chain_tee;

  typedef struct packed {
    logic        rst_n;
    logic [8:0]  b_bus;
    logic [6:0]  b_tag;
    logic [8:0]  a_bus;
    logic [5:0]  a_tag;
    logic [35:0] d_bus;
    logic [19:0] d_tag;
    logic [3:0]  y;
  } in_t;

  typedef struct packed {
    logic [8:0]  b_bus_in;
    logic [5:0]  b_tag_in;
    logic [8:0]  a_bus_out;
    logic [6:0]  a_tag_out;
    logic [35:0] d_bus_out;
    logic [23:0] d_tag_out;
    logic [3:0]  x;
    logic        conn;
    logic [3:0]  own;
    logic [7:0]  cnt;
  } out_t;

  typedef struct {
    in_t        in;
    logic       conn;
    logic [3:0] own;
    logic [7:0] cnt;
    logic [8:0] bbus;
    logic [3:0] x;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [8:0]  b_bus_out, a_bus_in;
  logic [6:0]  b_tag_out;
  logic [5:0]  a_tag_in;
  logic [35:0] dev_bus_in;
  logic [19:0] dev_tag_in;
  logic [3:0]  dev_y;

  logic [8:0]  b_bus_in0, b_bus_in1, a_bus_out0, a_bus_out1;
  logic [5:0]  b_tag_in0, b_tag_in1;
  logic [6:0]  a_tag_out0, a_tag_out1;
  logic [35:0] dev_bus_out0, dev_bus_out1;
  logic [23:0] dev_tag_out0, dev_tag_out1;
  logic [3:0]  dev_x0, dev_x1, owner0, owner1;
  logic        conn0, conn1;
  logic [7:0]  cnt0;
  logic [1:0]  cnt1;

  int   nerr = 0;
  int   nchk = 0;
  bit   mconn [2];
  logic [3:0] mown [2];
  int   mcnt [2];
  out_t q0 [$];
  out_t q1 [$];
  vec_t tbl [17];

  always #5 clk = ~clk;

  chain_tee #(.N_DEV(4), .PRIORITY(1'b1), .BYPASS_MASK(4'b0000), .CNT_W(8)) u_d0 (
    .clk(clk), .reset_n(reset_n),
    .b_bus_out(b_bus_out), .b_tag_out(b_tag_out), .b_bus_in(b_bus_in0), .b_tag_in(b_tag_in0),
    .a_bus_out(a_bus_out0), .a_tag_out(a_tag_out0), .a_bus_in(a_bus_in), .a_tag_in(a_tag_in),
    .dev_bus_out(dev_bus_out0), .dev_tag_out(dev_tag_out0), .dev_bus_in(dev_bus_in),
    .dev_tag_in(dev_tag_in), .dev_selection_x(dev_x0), .dev_selection_y(dev_y),
    .connected(conn0), .owner(owner0), .contention_count(cnt0));

  chain_tee #(.N_DEV(4), .PRIORITY(1'b0), .BYPASS_MASK(4'b0100), .CNT_W(2)) u_d1 (
    .clk(clk), .reset_n(reset_n),
    .b_bus_out(b_bus_out), .b_tag_out(b_tag_out), .b_bus_in(b_bus_in1), .b_tag_in(b_tag_in1),
    .a_bus_out(a_bus_out1), .a_tag_out(a_tag_out1), .a_bus_in(a_bus_in), .a_tag_in(a_tag_in),
    .dev_bus_out(dev_bus_out1), .dev_tag_out(dev_tag_out1), .dev_bus_in(dev_bus_in),
    .dev_tag_in(dev_tag_in), .dev_selection_x(dev_x1), .dev_selection_y(dev_y),
    .connected(conn1), .owner(owner1), .contention_count(cnt1));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference behaviour for configuration k (0: prio=1 no mask 8-bit, 1: prio=0 mask dev2 2-bit).
  task automatic model_step(input in_t v, input int k, output out_t e);
    logic [3:0] mask;
    bit         prio;
    int         cmax, pop, last, oi;
    logic [8:0] sb [5];
    logic [4:0] st [5];
    logic [8:0] ob, gb;
    logic [4:0] ot, gt;
    bit         nconn;
    logic [3:0] nown;
    logic       s, asel, bsel;
    mask = (k == 0) ? 4'b0000 : 4'b0100;
    prio = (k == 0);
    cmax = (k == 0) ? 255 : 3;
    e = '0;
    if (!v.rst_n) begin
      mconn[k] = 1'b0; mown[k] = 4'd0; mcnt[k] = 0;
    end else begin
      for (int d = 0; d < 4; d++) begin
        sb[d] = mask[d] ? 9'd0 : v.d_bus[d*9 +: 9];
        st[d] = mask[d] ? 5'd0 : v.d_tag[d*5 +: 5];
      end
      sb[4] = v.a_bus;
      st[4] = {v.a_tag[5:3], v.a_tag[1:0]};
      pop = 0; last = 0; ob = '0; ot = '0;
      for (int j = 0; j < 5; j++) begin
        ob = ob | sb[j];
        ot = ot | st[j];
        if (st[j][0]) begin pop++; last = j; end
      end
      if (!mconn[k]) begin
        nconn = (pop == 1) && v.b_tag[0];
        nown  = nconn ? 4'(last) : mown[k];
      end else begin
        oi    = int'(mown[k]);
        nconn = st[oi][0] && v.b_tag[0];
        nown  = mown[k];
      end
      oi = int'(nown);
      gb = nconn ? sb[oi] : ob;
      gt = nconn ? {st[oi][4:2], ot[1], st[oi][0]} : ot;
      s = prio ? v.b_tag[2] : v.a_tag[2];
      for (int d = 0; d < 4; d++) begin
        if (!mask[d]) begin
          e.x[d] = s;
          s = v.y[d];
          e.d_bus_out[d*9 +: 9] = v.b_bus;
          e.d_tag_out[d*6 +: 6] = {v.b_tag[6:3], v.b_tag[1:0]};
        end
      end
      asel = prio ? s : v.b_tag[2];
      bsel = prio ? v.a_tag[2] : s;
      if (pop > 1 && mcnt[k] < cmax) mcnt[k]++;
      e.b_bus_in  = gb;
      e.b_tag_in  = {gt[4:2], bsel, gt[1:0]};
      e.a_bus_out = v.b_bus;
      e.a_tag_out = {v.b_tag[6:3], asel, v.b_tag[1:0]};
      e.conn = nconn;
      e.own  = nown;
      e.cnt  = 8'(mcnt[k]);
      mconn[k] = nconn;
      mown[k]  = nown;
    end
  endtask

  function automatic out_t cap(input int k);
    out_t o;
    if (k == 0) o = '{b_bus_in0, b_tag_in0, a_bus_out0, a_tag_out0, dev_bus_out0, dev_tag_out0,
                      dev_x0, conn0, owner0, cnt0};
    else        o = '{b_bus_in1, b_tag_in1, a_bus_out1, a_tag_out1, dev_bus_out1, dev_tag_out1,
                      dev_x1, conn1, owner1, 8'(cnt1)};
    return o;
  endfunction

  task automatic cmp(input string nm, input out_t a, input out_t e);
    chk({nm, ".b_bus_in"},  64'(a.b_bus_in),  64'(e.b_bus_in));
    chk({nm, ".b_tag_in"},  64'(a.b_tag_in),  64'(e.b_tag_in));
    chk({nm, ".a_bus_out"}, 64'(a.a_bus_out), 64'(e.a_bus_out));
    chk({nm, ".a_tag_out"}, 64'(a.a_tag_out), 64'(e.a_tag_out));
    chk({nm, ".dev_bus"},   64'(a.d_bus_out), 64'(e.d_bus_out));
    chk({nm, ".dev_tag"},   64'(a.d_tag_out), 64'(e.d_tag_out));
    chk({nm, ".sel_x"},     64'(a.x),         64'(e.x));
    chk({nm, ".connected"}, 64'(a.conn),      64'(e.conn));
    chk({nm, ".owner"},     64'(a.own),       64'(e.own));
    chk({nm, ".count"},     64'(a.cnt),       64'(e.cnt));
  endtask

  // Drive one cycle of stimulus, queue the model's expectations, compare after the edge.
  task automatic apply(input in_t v);
    out_t e0, e1;
    reset_n = v.rst_n; b_bus_out = v.b_bus; b_tag_out = v.b_tag;
    a_bus_in = v.a_bus; a_tag_in = v.a_tag;
    dev_bus_in = v.d_bus; dev_tag_in = v.d_tag; dev_y = v.y;
    model_step(v, 0, e0); q0.push_back(e0);
    model_step(v, 1, e1); q1.push_back(e1);
    @(posedge clk);
    #1;
    cmp("d0", cap(0), q0.pop_front());
    cmp("d1", cap(1), q1.pop_front());
  endtask

  function automatic vec_t mk(input logic r, input logic [8:0] bb, input logic [6:0] bt,
                              input logic [5:0] at, input logic [35:0] db, input logic [19:0] dt,
                              input logic [3:0] y, input logic c, input logic [3:0] o,
                              input logic [7:0] n, input logic [8:0] eb, input logic [3:0] x);
    vec_t t;
    t.in   = '{r, bb, bt, 9'd0, at, db, dt, y};
    t.conn = c; t.own = o; t.cnt = n; t.bbus = eb; t.x = x;
    return t;
  endfunction

  initial begin
    in_t        v;
    logic [35:0] b1, b2;
    b1 = {9'h000, 9'h05A, 9'h000, 9'h00F};
    b2 = {9'h000, 9'h05A, 9'h1C3, 9'h00F};
    tbl[0]  = mk(0, 9'h1FF, 7'h7F, 6'h3F, '1, '1, 4'hF, 0, 0, 0, 9'h000, 4'b0000);
    tbl[1]  = mk(1, 9'h1A5, 7'h03, 6'h00, '0, '0, 4'h0, 0, 0, 0, 9'h000, 4'b0000);
    tbl[2]  = mk(1, 9'h1A5, 7'h07, 6'h00, '0, '0, 4'h3, 0, 0, 0, 9'h000, 4'b0111);
    tbl[3]  = mk(1, 9'h1A5, 7'h05, 6'h00, b1, 20'h00400, 4'h3, 1, 2, 0, 9'h05A, 4'b0111);
    for (int i = 4; i < 7; i++)
      tbl[i] = mk(1, 9'h1A5, 7'h05, 6'h01, b1, 20'h00400, 4'h3, 1, 2, 8'(i - 3), 9'h05A, 4'b0111);
    tbl[7]  = mk(1, 9'h1A5, 7'h05, 6'h00, b1, 20'h00400, 4'h3, 1, 2, 3, 9'h05A, 4'b0111);
    tbl[8]  = mk(1, 9'h1A5, 7'h05, 6'h00, b1, 20'h00000, 4'h3, 0, 2, 3, 9'h05F, 4'b0111);
    for (int i = 9; i < 14; i++)
      tbl[i] = mk(1, 9'h1A5, 7'h05, 6'h01, b1, 20'h00021, 4'h3, 0, 2, 8'(i - 5), 9'h05F, 4'b0111);
    tbl[14] = mk(1, 9'h1A5, 7'h05, 6'h00, b2, 20'h00020, 4'h3, 1, 1, 8, 9'h1C3, 4'b0111);
    tbl[15] = mk(1, 9'h1A5, 7'h04, 6'h00, b2, 20'h00020, 4'h3, 0, 1, 8, 9'h1DF, 4'b0111);
    tbl[16] = mk(1, 9'h1A5, 7'h01, 6'h04, b2, 20'h00000, 4'hF, 0, 1, 8, 9'h1DF, 4'b1110);

    for (int i = 0; i < 17; i++) begin
      apply(tbl[i].in);
      chk($sformatf("row%0d.connected", i), 64'(conn0),     64'(tbl[i].conn));
      chk($sformatf("row%0d.owner", i),     64'(owner0),    64'(tbl[i].own));
      chk($sformatf("row%0d.count", i),     64'(cnt0),      64'(tbl[i].cnt));
      chk($sformatf("row%0d.b_bus_in", i),  64'(b_bus_in0), 64'(tbl[i].bbus));
      chk($sformatf("row%0d.sel_x", i),     64'(dev_x0),    64'(tbl[i].x));
    end

    // Second configuration: A-first chain skipping dev2, saturated 2-bit count.
    chk("d1.sel_x_afirst",   64'(dev_x1),             64'(4'b1011));
    chk("d1.b_select_in",    64'(b_tag_in1[2]),       64'(1'b1));
    chk("d1.count_sat",      64'(cnt1),               64'(2'd3));
    chk("d1.masked_bus_out", 64'(dev_bus_out1[26:18]), 64'(9'd0));
    chk("d1.masked_tag_out", 64'(dev_tag_out1[17:12]), 64'(6'd0));

    // Reset in the middle of a connection.
    v = '{1'b1, 9'h000, 7'h01, 9'h000, 6'h00, {9'h0C3, 27'd0}, 20'h08000, 4'h0};
    apply(v);
    chk("mid.connected", 64'(conn0), 64'(1'b1));
    chk("mid.owner",     64'(owner0), 64'(4'd3));
    chk("mid.b_bus_in",  64'(b_bus_in0), 64'(9'h0C3));
    v.rst_n = 1'b0;
    apply(v);
    chk("rst.connected", 64'(conn0), 64'(1'b0));
    chk("rst.owner",     64'(owner0), 64'(4'd0));
    chk("rst.count",     64'(cnt1), 64'(2'd0));
    chk("rst.b_bus_in",  64'(b_bus_in0), 64'(9'h000));
    v.rst_n = 1'b1;
    apply(v);
    chk("rel.connected", 64'(conn0), 64'(1'b1));
    chk("rel.owner",     64'(owner0), 64'(4'd3));

    // Random traffic with sparse operational-in and occasional reset.
    for (int c = 0; c < 400; c++) begin
      v.rst_n = ($urandom_range(0, 60) != 0);
      v.b_bus = 9'($urandom);
      v.b_tag = {4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 7) != 0)};
      v.a_bus = 9'($urandom);
      v.a_tag = {3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0)};
      v.d_bus = 36'({$urandom, $urandom});
      for (int d = 0; d < 4; d++)
        v.d_tag[d*5 +: 5] = {4'($urandom), 1'($urandom_range(0, 3) == 0)};
      v.y = 4'($urandom);
      apply(v);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
